// File: rtl/mag_sq_pkg.sv
// mag_sq_pkg: shared FSM states and helpers for the odd-sum magnitude-squared stream
package mag_sq_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction
  function automatic logic [63:0] abs_s(input logic signed [63:0] x);
    return x[63] ? 64'(-x) : 64'(x);
  endfunction
endpackage

// File: rtl/odd_sum_step.sv
// odd_sum_step: adds up to STEP consecutive odd terms (2k+1) to a running square
module odd_sum_step
  import mag_sq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STEP   = 4
) (
  input  logic [DATA_W-1:0]   n,
  input  logic [DATA_W-1:0]   k,
  input  logic [2*DATA_W-1:0] acc,
  output logic [DATA_W-1:0]   k_next,
  output logic [2*DATA_W-1:0] acc_next,
  output logic                done
);
  localparam int AW = 2 * DATA_W;
  logic [DATA_W-1:0] rem;
  logic [AW-1:0] chain [STEP+1];
  assign rem = n - k;
  assign chain[0] = acc;
  for (genvar i = 0; i < STEP; i++) begin : g_t
    assign chain[i+1] = chain[i] + ((DATA_W'(i) < rem) ? (((AW'(k) + AW'(i)) << 1) + AW'(1)) : '0);
  end
  assign acc_next = chain[STEP];
  assign k_next = k + DATA_W'(min_u(32'(STEP), 32'(rem)));
  assign done = k_next == n;
endmodule

// File: rtl/mag_sq_odd_stream.sv
// mag_sq_odd_stream: streaming Re^2+Im^2 by odd-number accumulation with valid/ready and tag
module mag_sq_odd_stream
  import mag_sq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STEP   = 4,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*DATA_W-1:0]      out_mag_sq,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);
  localparam int AW = 2 * DATA_W;
  state_t state, state_nx;
  logic live, take, zero_in, fin, done_r, done_i;
  logic [DATA_W-1:0] a_r, a_i, n_r, n_i, k_r, k_i, k_r_nx, k_i_nx;
  logic [AW-1:0] acc_r, acc_i, acc_r_nx, acc_i_nx;
  logic [TAG_W-1:0] tag_q;
  assign a_r = DATA_W'(abs_s(64'(in_r)));
  assign a_i = DATA_W'(abs_s(64'(in_i)));
  assign zero_in = (a_r == '0) && (a_i == '0);
  assign in_ready = live && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign take = in_valid && in_ready;
  assign fin = (state == ST_RUN) && done_r && done_i;
  assign busy = state == ST_RUN;
  odd_sum_step #(.DATA_W(DATA_W), .STEP(STEP)) u_re (
    .n(n_r), .k(k_r), .acc(acc_r), .k_next(k_r_nx), .acc_next(acc_r_nx), .done(done_r)
  );
  odd_sum_step #(.DATA_W(DATA_W), .STEP(STEP)) u_im (
    .n(n_i), .k(k_i), .acc(acc_i), .k_next(k_i_nx), .acc_next(acc_i_nx), .done(done_i)
  );
  always_comb begin
    state_nx = state;
    if (state == ST_RUN) state_nx = fin ? ST_DONE : ST_RUN;
    else if (take) state_nx = zero_in ? ST_DONE : ST_RUN;
    else if ((state == ST_DONE) && out_ready) state_nx = ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      live       <= 1'b0;
      n_r        <= '0;
      n_i        <= '0;
      k_r        <= '0;
      k_i        <= '0;
      acc_r      <= '0;
      acc_i      <= '0;
      tag_q      <= '0;
      out_valid  <= 1'b0;
      out_mag_sq <= '0;
      out_tag    <= '0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      if (take) begin
        n_r   <= a_r;
        n_i   <= a_i;
        tag_q <= in_tag;
        k_r   <= '0;
        k_i   <= '0;
        acc_r <= '0;
        acc_i <= '0;
      end else if (state == ST_RUN) begin
        k_r   <= k_r_nx;
        k_i   <= k_i_nx;
        acc_r <= acc_r_nx;
        acc_i <= acc_i_nx;
      end
      if (fin) begin
        out_valid  <= 1'b1;
        out_mag_sq <= acc_r_nx + acc_i_nx;
        out_tag    <= tag_q;
      end else if (take && zero_in) begin
        out_valid  <= 1'b1;
        out_mag_sq <= '0;
        out_tag    <= in_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mag_sq_odd_stream.sv
// tb_mag_sq_odd_stream: directed and randomized checks of the magnitude-squared stream
module tb_mag_sq_odd_stream;
  typedef struct {logic [31:0] m; logic [7:0] t;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b1;
  logic signed [15:0] in_r = '0;
  logic signed [15:0] in_i = '0;
  logic [7:0] in_tag = '0;
  logic iv [3];
  logic ir [3];
  logic ov [3];
  logic bz [3];
  logic [31:0] om [3];
  logic [7:0] ot [3];
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  mag_sq_odd_stream #(.DATA_W(16), .STEP(4), .TAG_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_r(in_r), .in_i(in_i),
    .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready), .out_mag_sq(om[0]),
    .out_tag(ot[0]), .busy(bz[0])
  );
  mag_sq_odd_stream #(.DATA_W(16), .STEP(1), .TAG_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_r(in_r), .in_i(in_i),
    .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready), .out_mag_sq(om[1]),
    .out_tag(ot[1]), .busy(bz[1])
  );
  mag_sq_odd_stream #(.DATA_W(16), .STEP(64), .TAG_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_r(in_r), .in_i(in_i),
    .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready), .out_mag_sq(om[2]),
    .out_tag(ot[2]), .busy(bz[2])
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
    end
  endtask
  task automatic run_one(input int d, input int r, input int i, input int t,
                         input logic [31:0] exp, input int lat, input string nm);
    int c;
    c = 0;
    while (!ir[d] && c < 100) begin
      tick;
      c++;
    end
    chk({nm, "_in_ready"}, 64'(ir[d]), 64'(1));
    in_r = 16'(r);
    in_i = 16'(i);
    in_tag = 8'(t);
    iv[d] = 1'b1;
    tick;
    iv[d] = 1'b0;
    c = 1;
    while (!ov[d] && c < 2000) begin
      tick;
      c++;
    end
    chk({nm, "_latency"}, 64'(c), 64'(lat));
    chk({nm, "_mag"}, 64'(om[d]), 64'(exp));
    chk({nm, "_tag"}, 64'(ot[d]), 64'(t));
  endtask
  initial begin
    int c, sent, got, cyc, sr, si;
    logic acc, ovr;
    for (int d = 0; d < 3; d++) iv[d] = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", 64'(ir[0]), 64'(0));
    chk("rst_out_valid", 64'(ov[0]), 64'(0));
    chk("rst_mag", 64'(om[0]), 64'(0));
    chk("rst_tag", 64'(ot[0]), 64'(0));
    chk("rst_busy", 64'(bz[0]), 64'(0));
    rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", 64'(ir[0]), 64'(1));
    // basic, zero and single-component cases
    run_one(0, 3, -4, 5, 32'd25, 2, "t1");
    tick;
    chk("t1_one_cycle", 64'(ov[0]), 64'(0));
    chk("t1_idle", 64'(bz[0]), 64'(0));
    run_one(0, 0, 0, 1, 32'd0, 1, "t2_zero");
    run_one(0, 0, 7, 2, 32'd49, 3, "t2_s4");
    run_one(1, 0, 7, 3, 32'd49, 8, "t2_s1");
    run_one(2, -32768, -32768, 4, 32'h8000_0000, 513, "t3_s64");
    tick;
    // backpressure hold, then simultaneous output/input transfer
    out_ready = 1'b0;
    run_one(0, 10, 2, 7, 32'd104, 4, "t4");
    in_r = 16'sd3;
    in_i = 16'sd4;
    in_tag = 8'd9;
    iv[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      chk("t4_hold_valid", 64'(ov[0]), 64'(1));
      chk("t4_hold_mag", 64'(om[0]), 64'(104));
      chk("t4_hold_tag", 64'(ot[0]), 64'(7));
      chk("t4_stall_ready", 64'(ir[0]), 64'(0));
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("t4_release_ready", 64'(ir[0]), 64'(1));
    chk("t4_release_valid", 64'(ov[0]), 64'(1));
    tick;
    iv[0] = 1'b0;
    chk("t4_out_taken", 64'(ov[0]), 64'(0));
    chk("t4_in_taken", 64'(bz[0]), 64'(1));
    c = 1;
    while (!ov[0] && c < 100) begin
      tick;
      c++;
    end
    chk("t4_next_latency", 64'(c), 64'(2));
    chk("t4_next_mag", 64'(om[0]), 64'(25));
    chk("t4_next_tag", 64'(ot[0]), 64'(9));
    tick;
    // random traffic against an in-order scoreboard
    sent = 0;
    got = 0;
    cyc = 0;
    sr = int'($urandom_range(0, 400)) - 200;
    si = int'($urandom_range(0, 400)) - 200;
    in_r = 16'(sr);
    in_i = 16'(si);
    in_tag = 8'(sent);
    while ((sent < 256 || got < 256) && cyc < 40000) begin
      #1;
      acc = iv[0] && ir[0];
      ovr = ov[0] && out_ready;
      if (ovr) begin
        if (q.size() == 0) begin
          chk("t5_extra_output", 64'(got), 64'(sent));
        end else begin
          chk("t5_mag", 64'(om[0]), 64'(q[0].m));
          chk("t5_tag", 64'(ot[0]), 64'(q[0].t));
          void'(q.pop_front());
          got++;
        end
      end
      if (acc) q.push_back(exp_t'{32'(sr * sr + si * si), 8'(sent)});
      tick;
      cyc++;
      if (acc) begin
        sent++;
        iv[0] = 1'b0;
        sr = int'($urandom_range(0, 400)) - 200;
        si = int'($urandom_range(0, 400)) - 200;
        if ($urandom_range(0, 7) == 0) begin
          sr = 0;
          si = 0;
        end
      end
      out_ready = $urandom_range(0, 3) != 0;
      if (sent < 256 && !iv[0]) iv[0] = $urandom_range(0, 2) != 0;
      in_r = 16'(sr);
      in_i = 16'(si);
      in_tag = 8'(sent);
    end
    chk("t5_outputs", 64'(got), 64'(256));
    chk("t5_inputs", 64'(sent), 64'(256));
    chk("t5_leftover", 64'(q.size()), 64'(0));
    iv[0] = 1'b0;
    out_ready = 1'b1;
    tick;
    tick;
    // reset in the middle of a long run abandons the sample
    in_r = 16'sd1000;
    in_i = 16'sd1000;
    in_tag = 8'd20;
    iv[0] = 1'b1;
    tick;
    iv[0] = 1'b0;
    for (int j = 0; j < 5; j++) tick;
    chk("t6_running", 64'(bz[0]), 64'(1));
    rst_n = 1'b0;
    tick;
    chk("t6_rst_valid", 64'(ov[0]), 64'(0));
    chk("t6_rst_mag", 64'(om[0]), 64'(0));
    chk("t6_rst_busy", 64'(bz[0]), 64'(0));
    chk("t6_rst_in_ready", 64'(ir[0]), 64'(0));
    rst_n = 1'b1;
    tick;
    chk("t6_no_output", 64'(ov[0]), 64'(0));
    run_one(0, 2, 2, 11, 32'd8, 2, "t6_next");
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
